layer1_mac_unit: RTL and testbench
==================================

# layer1_mac_unit

Multiply-accumulate stage of the layer-1 output path of the LSTM sigmoid network. It sits directly downstream of the layer-1 acknowledge counter and starts when that counter raises its MAC acknowledge. It then walks N_IN weight/input pairs through an external read port and accumulates their products plus a bias. The saturated fixed-point sum goes to the sigmoid stage with a held acknowledge.

## Interface
- N_IN, 3: number of weight/input pairs per activation (≥1)
- DW, 16: signed fixed-point data width (Q(DW-FRAC).FRAC)
- FRAC, 8: fractional bits
- AW, 2: address width, 2^AW ≥ N_IN
- clk  in  1  clock; all state updates on the falling edge
- rst  in  1  asynchronous, active-low reset
- ack_mac  in  1  start request from counter stage, level, rising edge significant
- addr  out  AW  pair index presented to weight/input storage
- x_in  in  DW  signed input value for addr, valid one clock after addr
- w_in  in  DW  signed weight for addr, valid one clock after addr
- bias  in  DW  signed bias, stable while busy
- busy  out  1  accumulation in progress
- result  out  DW  signed saturated sum to sigmoid stage
- ack_sig  out  1  result valid, held high until next accepted start

## Operation
- Reset (rst=0, asynchronous): state=IDLE; addr=0, busy=0, result=0, ack_sig=0, acc=0, ack_mac_d=0.
- ack_mac_d registers ack_mac every edge; start = ack_mac & ~ack_mac_d.
- States: IDLE, ACC, OUT.
- IDLE: on start, go to ACC. Load acc with sign-extended bias shifted left by FRAC. Set addr=0, cnt=0, busy=1, ack_sig=0. result keeps its old value.
- ACC, each edge: acc += sext(x_in*w_in). Product is signed 2*DW bits. cnt++.
  - If cnt==N_IN-1, go to OUT.
  - Otherwise addr=cnt+1.
- OUT: result = sat(acc >>> FRAC).
  - Arithmetic shift, truncation toward −∞.
  - Saturate to [−2^(DW-1), 2^(DW-1)−1].
  - ack_sig=1, busy=0, addr=0, go to IDLE.
- Accumulator width: 2*DW + clog2(N_IN+1) + 1 bits, so no internal wrap ever occurs.
- start while busy is ignored. A start is accepted only from IDLE, including the edge right after OUT.
- ack_mac held high does not retrigger. A new start needs ack_mac to go low and then high again.
- Reset mid-operation aborts immediately. No ack_sig is produced and the partial acc is discarded.

## Timing
- E0: falling edge where start is detected in IDLE.
- addr=k is driven after E0+k for k=0..N_IN−1. The pair for addr=k is accumulated at edge E0+k+1.
- OUT is entered after edge E0+N_IN.
- result and ack_sig update at E0+N_IN+1. Latency is N_IN+1 falling edges; default is 4.
- busy is high from E0 through E0+N_IN+1, and low after that edge.
- Read storage must return data for addr before the next falling edge, e.g. a ROM registered on the rising edge.
- Minimum start-to-start spacing: N_IN+2 edges, since ack_mac must be sampled low at least once.

## Test plan
- Basic Q8.8 run:
  - Stimulus: x={0x0100,0x0200,0xFF80}, w={0x0080,0x0040,0x0200}, bias=0x0100, ack_mac 0→1 at E0.
  - Required: addr goes 0,1,2; result=0x0100; ack_sig=1 at E0+4; busy low after E0+4.
- Positive saturation:
  - Stimulus: all x=w=0x7FFF, bias=0x7FFF.
  - Required: result=0x7FFF, ack_sig=1.
- Negative saturation and rounding:
  - Stimulus: x=0x7FFF, w=0x8000, all pairs, bias=0x8000. Then a second run with x={0x0001,0,0}, w={0xFFFF,0,0}, bias=0.
  - Required: first run result=0x8000. Second run result=0xFFFF (−1 LSB, floor).
- Start handling:
  - Stimulus: ack_mac held high for 10 edges after a completed run. Then ack_mac pulsed low-high during busy of a fresh run.
  - Required: exactly one accumulation per rising edge accepted from IDLE. The mid-busy pulse has no effect on result or on the addr sequence.
- Reset mid-operation:
  - Stimulus: rst asserted low between E0+2 and E0+3.
  - Required: busy, ack_sig, addr and result are 0 immediately, asynchronously. No ack_sig appears afterwards.
  - Required: the next clean start yields the correct sum.
- Back-to-back:
  - Stimulus: second start detected the edge after ack_sig rises.
  - Required: ack_sig drops at that edge, and the new result appears N_IN+1 edges later.

Source files
------------

// File: rtl/layer1_mac_unit.sv
// Layer-1 multiply-accumulate: bias + sum(x*w) over N_IN pairs, saturated to DW bits.
// Latency: N_IN+1 falling edges from start detection to result/ack_sig.
// Backpressure: none; starts arriving while busy are ignored, ack_sig held until next start.
module layer1_mac_unit #(
  parameter int N_IN = 3,
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ack_mac,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] w_in,
  input  logic [DW-1:0] bias,
  output logic          busy,
  output logic [DW-1:0] result,
  output logic          ack_sig
);

  // Wide enough that N_IN full-scale products plus the shifted bias never wrap.
  localparam int ACCW = 2*DW + $clog2(N_IN+1) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [AW-1:0] LAST = AW'(N_IN-1);

  logic [1:0]             state;
  logic [AW-1:0]          cnt;
  logic signed [ACCW-1:0] acc;
  logic                   ack_mac_d;
  logic                   start;

  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] bias_ext;
  logic signed [ACCW-1:0] shifted;
  logic [DW-1:0]          sat_val;

  assign start = ack_mac & ~ack_mac_d;

  // Product and sign extensions of the datapath operands.
  always_comb begin
    prod     = $signed(x_in) * $signed(w_in);
    prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
    bias_ext = {{(ACCW-DW){bias[DW-1]}}, bias};
  end

  // Floor-shift the accumulator back to Q format and clamp to the DW-bit signed range.
  always_comb begin
    shifted = acc >>> FRAC;
    sat_val = shifted[DW-1:0];
    if (!((&shifted[ACCW-1:DW-1]) || ~(|shifted[ACCW-1:DW-1]))) begin
      sat_val = shifted[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  // Control FSM and accumulator, all updated on the falling edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      ack_mac_d <= 1'b0;
      addr      <= '0;
      busy      <= 1'b0;
      result    <= '0;
      ack_sig   <= 1'b0;
    end else begin
      ack_mac_d <= ack_mac;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_ACC;
            acc     <= bias_ext <<< FRAC;
            addr    <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            ack_sig <= 1'b0;
          end
        end
        S_ACC: begin
          acc <= acc + prod_ext;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_OUT;
          end else begin
            addr <= cnt + 1'b1;
          end
        end
        S_OUT: begin
          result  <= sat_val;
          ack_sig <= 1'b1;
          busy    <= 1'b0;
          addr    <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer1_mac_unit.sv
// Self-checking bench for layer1_mac_unit: fixed vector table, corner sequences, random runs.
// Storage is modelled as a ROM registered on the rising edge.
// Expected sums come from a plain integer model of bias + sum(x*w), floor shift and clamp.
module tb_layer1_mac_unit;

  localparam int N    = 3;
  localparam int DW   = 16;
  localparam int FRAC = 8;
  localparam int AW   = 2;

  typedef struct packed {
    logic [N-1:0][DW-1:0] x;
    logic [N-1:0][DW-1:0] w;
    logic [DW-1:0]        b;
    logic [DW-1:0]        exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ack_mac;
  logic [AW-1:0] addr;
  logic [DW-1:0] x_in;
  logic [DW-1:0] w_in;
  logic [DW-1:0] bias;
  logic          busy;
  logic [DW-1:0] result;
  logic          ack_sig;

  logic [DW-1:0] xmem [4];
  logic [DW-1:0] wmem [4];
  logic [DW-1:0] last_result;

  int n_chk  = 0;
  int n_fail = 0;

  vec_t tbl [5];

  layer1_mac_unit #(.N_IN(N), .DW(DW), .FRAC(FRAC), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .ack_mac (ack_mac),
    .addr    (addr),
    .x_in    (x_in),
    .w_in    (w_in),
    .bias    (bias),
    .busy    (busy),
    .result  (result),
    .ack_sig (ack_sig)
  );

  always #5 clk = ~clk;

  // ROM registered on the rising edge
  always @(posedge clk) begin
    x_in = xmem[addr];
    w_in = wmem[addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [DW-1:0] x0, x1, x2, w0, w1, w2, b, e);
    vec_t v;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.b = b; v.exp = e;
    return v;
  endfunction

  function automatic logic [DW-1:0] model(input vec_t v);
    longint s;
    s = longint'($signed(v.b)) * (longint'(1) << FRAC);
    for (int i = 0; i < N; i++)
      s += longint'($signed(v.x[i])) * longint'($signed(v.w[i]));
    s = s >>> FRAC;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return {{8{r[7]}}, r[7:0]};
      default: return r[DW-1:0];
    endcase
  endfunction

  // One complete accumulation with per-edge checks of addr/busy/ack_sig and the final result.
  task automatic run_op(input vec_t v, input bit b2b, input bit drop_early, input bit pulse);
    for (int i = 0; i < N; i++) begin
      xmem[i] = v.x[i];
      wmem[i] = v.w[i];
    end
    bias = v.b;
    if (!b2b) begin
      ack_mac = 1'b0;
      @(negedge clk);
      @(posedge clk);
    end
    ack_mac = 1'b1;
    @(negedge clk);   // E0
    @(posedge clk);
    chk("e0_busy", busy, 1);
    chk("e0_ack_sig", ack_sig, 0);
    chk("e0_addr", addr, 0);
    chk("e0_result_held", result, last_result);
    if (drop_early) ack_mac = 1'b0;
    for (int k = 1; k < N; k++) begin
      @(negedge clk);
      @(posedge clk);
      chk("addr_seq", addr, k);
      chk("busy_mid", busy, 1);
      if (pulse && k == 1) ack_mac = 1'b0;
      if (pulse && k == 2) ack_mac = 1'b1;
    end
    @(negedge clk);   // E0+N
    @(posedge clk);
    chk("last_acc_busy", busy, 1);
    chk("last_acc_ack_sig", ack_sig, 0);
    @(negedge clk);   // E0+N+1
    @(posedge clk);
    chk("result", result, v.exp);
    chk("done_ack_sig", ack_sig, 1);
    chk("done_busy", busy, 0);
    chk("done_addr", addr, 0);
    last_result = v.exp;
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      xmem[i] = '0;
      wmem[i] = '0;
    end
    tbl[0] = mk(16'h0100, 16'h0200, 16'hFF80, 16'h0080, 16'h0040, 16'h0200, 16'h0100, 16'h0100);
    tbl[1] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    tbl[2] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    tbl[3] = mk(16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    tbl[4] = mk(16'h0180, 16'h0000, 16'h0000, 16'h0100, 16'h1234, 16'h0000, 16'h0080, 16'h0200);

    rst = 1'b0;
    ack_mac = 1'b0;
    bias = '0;
    last_result = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_ack_sig", ack_sig, 0);
    chk("rst_addr", addr, 0);
    chk("rst_result", result, 0);
    @(posedge clk);
    rst = 1'b1;

    // Table vectors; ack_mac stays high after each run.
    for (int t = 0; t < 5; t++) run_op(tbl[t], 1'b0, 1'b0, 1'b0);

    // Held-high ack_mac after a completed run must not retrigger.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      @(posedge clk);
      chk("hold_busy", busy, 0);
      chk("hold_ack_sig", ack_sig, 1);
      chk("hold_result", result, last_result);
    end

    // Low-high pulse while busy is ignored.
    v = mk(16'h0300, 16'hFE00, 16'h0040, 16'h0100, 16'h0080, 16'hFC00, 16'hFF00, 16'h0000);
    v.exp = model(v);
    run_op(v, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(posedge clk);
    chk("pulse_no_retrigger_busy", busy, 0);
    chk("pulse_no_retrigger_ack", ack_sig, 1);

    // Back-to-back: second start on the edge right after ack_sig rises.
    run_op(tbl[4], 1'b0, 1'b1, 1'b0);
    run_op(tbl[0], 1'b1, 1'b0, 1'b0);

    // Reset between E0+2 and E0+3 aborts the run.
    for (int i = 0; i < N; i++) begin
      xmem[i] = tbl[1].x[i];
      wmem[i] = tbl[1].w[i];
    end
    bias = tbl[1].b;
    ack_mac = 1'b0;
    @(negedge clk);
    @(posedge clk);
    ack_mac = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      @(posedge clk);
    end
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ack_sig", ack_sig, 0);
    chk("abort_addr", addr, 0);
    chk("abort_result", result, 0);
    ack_mac = 1'b0;
    @(negedge clk);
    @(posedge clk);
    rst = 1'b1;
    last_result = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      @(posedge clk);
      chk("post_abort_ack_sig", ack_sig, 0);
      chk("post_abort_busy", busy, 0);
    end
    run_op(tbl[0], 1'b0, 1'b0, 1'b0);

    // Randomised runs against the arithmetic model.
    for (int r = 0; r < 25; r++) begin
      v = mk(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 16'h0000);
      v.exp = model(v);
      run_op(v, 1'b0, (r % 3) == 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
